// File: rtl/cla_adder.sv
// -----------------------------------------------------------------------------
// cla_adder
//
// Registered 4-bit carry-lookahead adder. It computes a + b + cin. Every carry
// is a flat sum-of-products of the bit generate/propagate terms and cin, so no
// carry depends on another computed carry. The group generate/propagate
// outputs let a parent combine several instances through a second-level
// lookahead unit. Sum, carry-out and group terms all come out of a single
// register stage, which gives a latency of one cycle.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-high reset; clears all outputs
//   a     in   WIDTH  operand A, unsigned
//   b     in   WIDTH  operand B, unsigned
//   cin   in   1      carry-in
//   sum   out  WIDTH  registered (a + b + cin) bits [3:0]
//   cout  out  1      registered carry-out, bit 4 of the result
//   gg    out  1      registered group generate (independent of cin)
//   gp    out  1      registered group propagate (independent of cin)
// -----------------------------------------------------------------------------
module cla_adder #(
    // The carry equations below are written out for exactly four bits.
    // Build wider adders by cascading instances, not by changing this value.
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             gg,
    output logic             gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_next;
    logic       gg_next;
    logic       gp_next;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is written out in full from g, p and cin. None of them uses
    // a lower carry, so the carry logic is only two levels deep.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum_next = p ^ c[3:0];

    // The group terms leave cin out, so a parent lookahead unit can form
    // this block's carry-out as gg | gp & cin without waiting for the block.
    assign gg_next = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
    assign gp_next = &p;

    // NOTE: use non-blocking assignments for registers. Every flop then
    // samples the pre-edge value, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            gg   <= 1'b0;
            gp   <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= c[4];
            gg   <= gg_next;
            gp   <= gp_next;
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_adder
//
// Self-checking bench for cla_adder. A reference model built from plain
// integer arithmetic gives the expected {cout, sum, gg, gp}:
//   {cout, sum} = a + b + cin
//   gg          = (a + b) > 15   (a carry leaves the group with cin = 0)
//   gp          = (a + b) == 15  (a carry-in would pass straight through)
// The inputs change 1 ns after a rising edge. The outputs are sampled 1 ns
// after a rising edge, away from the edge itself.
// -----------------------------------------------------------------------------
module tb_cla_adder;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       gg;
    logic       gp;

    int checks = 0;
    int errors = 0;

    cla_adder #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .gg   (gg),
        .gp   (gp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference model returns {cout, sum[3:0], gg, gp}.
    function automatic logic [6:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mcin);
        int total;
        int ab;
        logic [4:0] res;
        ab    = int'(ma) + int'(mb);
        total = ab + int'(mcin);
        res   = total[4:0];
        return {res, (ab > 15), (ab == 15)};
    endfunction

    // Wait for the next rising edge, then move 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp_v;
        // rst is high from time zero, so the outputs must already be zero.
        #1;
        checks++;
        if ({cout, sum, gg, gp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_initial: got %b, expected %b", {cout, sum, gg, gp}, 7'b0);
        end
        // Hold rst high across several edges with the inputs at their maximum.
        a = 4'hF; b = 4'hF; cin = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cout, sum, gg, gp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_held: got %b, expected %b", {cout, sum, gg, gp}, 7'b0);
        end
        // After release and one edge: sum=1111, cout=1, gg=1, gp=0.
        rst = 1'b0;
        tick();
        exp_v = model(4'hF, 4'hF, 1'b1);
        checks++;
        if ({cout, sum, gg, gp} !== exp_v || exp_v !== 7'b1_1111_1_0) begin
            errors++;
            $display("FAIL reset_release: got %b, expected %b", {cout, sum, gg, gp}, 7'b1_1111_1_0);
        end
        // Assert rst in the middle of a cycle. The clear must happen with no clock edge.
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({cout, sum, gg, gp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got %b, expected %b", {cout, sum, gg, gp}, 7'b0);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_directed();
        // These are the cases from the operation description: no carry,
        // carry-out and carry-in.
        logic [3:0] ta [11] = '{4'b0000, 4'b0001, 4'b0111, 4'b1001, 4'b1100, 4'b1111,
                                4'b1000, 4'b1110, 4'b1010, 4'b1101, 4'b1001};
        logic [3:0] tb [11] = '{4'b0000, 4'b0010, 4'b0111, 4'b0110, 4'b1100, 4'b1110,
                                4'b1000, 4'b1110, 4'b1010, 4'b1000, 4'b0110};
        logic       tc [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] tr [11] = '{5'b0_0000, 5'b0_0011, 5'b0_1110, 5'b0_1111, 5'b1_1000,
                                5'b1_1101, 5'b1_0000, 5'b1_1101, 5'b1_0101, 5'b1_0110,
                                5'b1_0000};
        logic [6:0] exp_v;
        for (int i = 0; i < 11; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i];
            tick();
            exp_v = model(ta[i], tb[i], tc[i]);
            checks++;
            if ({cout, sum, gg, gp} !== exp_v || exp_v[6:2] !== tr[i]) begin
                errors++;
                $display("FAIL directed_%0d (%b+%b+%b): got %b, expected %b",
                         i, ta[i], tb[i], tc[i], {cout, sum, gg, gp}, exp_v);
            end
        end
        // Both 1001+0110 cases are a full propagate chain: gp=1 and gg=0.
        checks++;
        if ({gg, gp} !== 2'b01) begin
            errors++;
            $display("FAIL directed_propagate_chain: got gg,gp=%b, expected 01", {gg, gp});
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_v;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        // Apply a new operand set on every edge. Each result must appear
        // exactly one cycle later, with no bubbles in between.
        for (int i = 0; i < 64; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            a = ra; b = rb; cin = rc;
            tick();
            exp_v = model(ra, rb, rc);
            checks++;
            if ({cout, sum, gg, gp} !== exp_v) begin
                errors++;
                $display("FAIL back_to_back_%0d (%h+%h+%b): got %b, expected %b",
                         i, ra, rb, rc, {cout, sum, gg, gp}, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        logic [6:0] exp_v;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            a = ra; b = rb; cin = rc;
            tick();
            exp_v = model(ra, rb, rc);
            // Toggle the inputs inside the cycle. The registered outputs
            // must keep the result that was captured at the edge.
            #1 a = ~ra; b = ~rb;
            #1 cin = ~rc;
            #1 a = 4'($urandom_range(0, 15));
            checks++;
            if ({cout, sum, gg, gp} !== exp_v) begin
                errors++;
                $display("FAIL glitch_hold_%0d: got %b, expected %b",
                         i, {cout, sum, gg, gp}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp_v;
        // Put operands on the inputs, then assert rst before the edge that
        // would capture them. That result must be discarded.
        a = 4'hA; b = 4'h7; cin = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if ({cout, sum, gg, gp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_discard: got %b, expected %b", {cout, sum, gg, gp}, 7'b0);
        end
        rst = 1'b0;
        a = 4'h3; b = 4'h4; cin = 1'b0;
        tick();
        exp_v = model(4'h3, 4'h4, 1'b0);
        checks++;
        if ({cout, sum, gg, gp} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_first: got %b, expected %b", {cout, sum, gg, gp}, exp_v);
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] exp_v;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        for (int i = 0; i < 512; i++) begin
            ra = 4'(i >> 5);
            rb = 4'(i >> 1);
            rc = 1'(i);
            a = ra; b = rb; cin = rc;
            tick();
            exp_v = model(ra, rb, rc);
            checks++;
            if ({cout, sum, gg, gp} !== exp_v) begin
                errors++;
                $display("FAIL exhaustive (%h+%h+%b): got %b, expected %b",
                         ra, rb, rc, {cout, sum, gg, gp}, exp_v);
            end
            // Lookahead invariant: the carry-out follows from the group terms.
            checks++;
            if (cout !== (gg | (gp & rc))) begin
                errors++;
                $display("FAIL invariant (%h+%h+%b): cout=%b, gg|gp&cin=%b",
                         ra, rb, rc, cout, gg | (gp & rc));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'h0;
        b   = 4'h0;
        cin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_adder.md
# cla_adder

Registered 4-bit carry-lookahead adder. Computes a + b + cin with parallel generate/propagate carry logic, so no ripple carry chain, and registers the sum and carry-out on the clock. It is a leaf arithmetic block. Its group generate/propagate outputs let a parent cascade several instances through a second-level lookahead unit.

## Interface
- WIDTH, 4, operand width; fixed at 4 for this block. Wider adders cascade instances.
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry-in
- sum  output  4  registered a + b + cin, bits [3:0]
- cout  output  1  registered carry-out, bit 4 of the full result
- gg  output  1  registered group generate
- gp  output  1  registered group propagate

## Operation
- Per bit i = 0..3:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
- Carries, fully expanded two-level sum-of-products. No carry may depend on a lower computed carry.
  - c0 = cin
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
- sum[i] = p[i] ^ c[i]
- cout = c4
- Group terms:
  - gg = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - gp = p3·p2·p1·p0
  - Both are independent of cin. Invariant: c4 = gg | gp·cin.
- Arithmetic is unsigned and modulo 32 across {cout, sum}. There is no overflow flag. Maximum result is 15 + 15 + 1 = 31 (cout = 1, sum = 1111).
- X/Z inputs are not handled. Operands are expected to be driven.

## Timing
- Combinational lookahead feeds one register stage for sum, cout, gg and gp.
- Latency is 1 cycle:
  - Inputs are sampled at rising edge k.
  - Results are visible after edge k.
  - Results are held until edge k+1.
- No handshake. A new operand set may be accepted every cycle.
- rst asserted forces sum = 0000, cout = 0, gg = 0, gp = 0 immediately, independent of clk.
- Outputs stay at these values for as long as rst is high.
- Reset mid-operation: any in-flight result is discarded.
- After rst deasserts, the first valid result appears after the first rising edge.
- Inputs changing between edges have no effect on the outputs until the next edge.

## Test plan
- Reset: assert rst while holding a=1111, b=1111, cin=1 -> all outputs are 0 with no clock edge. After release and one edge -> sum=1111, cout=1, gg=1, gp=0.
- No-carry cases, each checked one edge after apply:
  - 0000+0000+0 -> sum 0000, cout 0
  - 0001+0010+0 -> 0011, 0
  - 0111+0111+0 -> 1110, 0
  - 1001+0110+0 -> 1111, 0, gp=1
- Carry-out cases:
  - 1100+1100+0 -> 1000, 1
  - 1111+1110+0 -> 1101, 1
  - 1000+1000+0 -> 0000, 1
- Carry-in cases:
  - 1110+1110+1 -> 1101, 1
  - 1010+1010+1 -> 0101, 1
  - 1101+1000+1 -> 0110, 1
  - 1001+0110+1 -> 0000, 1 (full propagate chain, gp=1, gg=0)
- Back-to-back operand sets on consecutive edges:
  - Each result appears exactly one cycle later with no bubbles.
  - Mid-cycle input glitches never reach the outputs.
- Exhaustive sweep of all 512 combinations of (a, b, cin) -> {cout, sum} equals a+b+cin one cycle later, and c4 == gg | gp·cin holds throughout.
